// File: rtl/replay_buf.sv
// ---------------------------------------------------------------------------
// replay_buf -- data-link-layer transmit replay buffer.
//
// Holds sequence-stamped, LCRC-protected TLP frames until they are
// acknowledged. It forwards each frame to the PHY and processes ACK/NAK DLLPs
// to purge acknowledged frames. Outstanding frames are replayed on a NAK or on
// replay-timer expiry. Consecutive replays are counted, and a link retrain is
// requested when that count rolls over.
//
// Parameters:
//   DEPTH    frame slots (power of two, <= 2^(SEQ_W-1))
//   DATA_W   frame width (sequence number lives at [SEQ_W+111:112])
//   SEQ_W    sequence-number width
//   TIMEOUT  replay-timer expiry in clk cycles
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-low reset
//   frame_in/_valid/_ready   stamped frame from the CRC stage
//   dllp_valid/_nak/_seq     ACK/NAK DLLP (single-cycle pulse)
//   tx_data/_valid/_ready    frame stream to the PHY
//   replay_active   high while replaying
//   retrain         one-cycle link-retrain request
//   dllp_err        one-cycle pulse for a DLLP naming a non-outstanding seq
//   replay_cnt      applied-rewind statistics counter
//
// Optional feature macro: REPLAY_STATS_EN (enables the replay_cnt counter;
// otherwise replay_cnt is tied to zero).
// ---------------------------------------------------------------------------
module replay_buf #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned SEQ_W   = 12,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] frame_in,
    input  logic              frame_valid,
    output logic              frame_ready,
    input  logic              dllp_valid,
    input  logic              dllp_nak,
    input  logic [SEQ_W-1:0]  dllp_seq,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              replay_active,
    output logic              retrain,
    output logic              dllp_err,
    output logic [15:0]       replay_cnt
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned PW      = AW + 1;
    localparam int unsigned TW      = $clog2(TIMEOUT);
    localparam int unsigned SEQ_LSB = 112;

    typedef enum logic {
        ST_NORMAL,
        ST_REPLAY
    } state_t;

    // Frame storage; contents survive reset.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     ack_ptr_q, ack_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    state_t            state_q, state_d;
    logic              rewind_pending_q, rewind_pending_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [1:0]        replay_num_q, replay_num_d;

    logic              frame_ready_q, frame_ready_d;
    logic              tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              replay_active_q, replay_active_d;
    logic              retrain_q, retrain_d;
    logic              dllp_err_q, dllp_err_d;

    logic [PW-1:0]     tx_out;
    logic [SEQ_W-1:0]  oldest_seq;
    logic [SEQ_W-1:0]  n_ack;
    logic              wr_en;
    logic              handshake;
    logic              stalled;
    logic              purge;
    logic              dup;
    logic              bad;
    logic              nak_req;
    logic              expire;
    logic              tmo_req;
    logic              req;
    logic              rewind_go;

    // Next-state and registered-output logic.
    always_comb begin
        wr_ptr_d         = wr_ptr_q;
        ack_ptr_d        = ack_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        state_d          = state_q;
        rewind_pending_d = rewind_pending_q;
        timer_d          = timer_q;
        replay_num_d     = replay_num_q;
        retrain_d        = 1'b0;
        dllp_err_d       = 1'b0;

        // Frames already sent but not yet acknowledged bound the legal ACK range.
        tx_out     = rd_ptr_q - ack_ptr_q;
        oldest_seq = mem_q[ack_ptr_q[AW-1:0]][SEQ_LSB +: SEQ_W];
        n_ack      = dllp_seq - oldest_seq + SEQ_W'(1);

        wr_en     = frame_valid && frame_ready_q;
        handshake = tx_valid_q && tx_ready;
        stalled   = tx_valid_q && !tx_ready;

        purge   = dllp_valid && (n_ack != '0) && (n_ack <= SEQ_W'(tx_out));
        dup     = dllp_valid && (n_ack == '0);
        bad     = dllp_valid && !purge && !dup;
        nak_req = dllp_valid && dllp_nak && !bad;

        expire  = (state_q == ST_NORMAL) && (rd_ptr_q != ack_ptr_q) &&
                  !rewind_pending_q && (timer_q == TW'(TIMEOUT - 1));
        // An ACK that purges in the expiry cycle cancels the timeout.
        tmo_req = expire && !purge;
        req     = nak_req || tmo_req;

        // A rewind never yanks a beat the PHY is currently stalling on.
        rewind_go = (rewind_pending_q || req) && !stalled;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (purge) begin
            ack_ptr_d = ack_ptr_q + PW'(n_ack);
        end
        if (handshake) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        // Keep rd_ptr inside the unacknowledged window.
        if ((ack_ptr_d - ack_ptr_q) > (rd_ptr_d - ack_ptr_q)) begin
            rd_ptr_d = ack_ptr_d;
        end
        if (rewind_go) begin
            rd_ptr_d = ack_ptr_d;
        end

        // Purge clears the consecutive-replay count before a new request counts.
        replay_num_d = purge ? 2'd0 : replay_num_q;
        if (req && !rewind_pending_q) begin
            if (replay_num_d == 2'd3) begin
                retrain_d    = 1'b1;
                replay_num_d = 2'd0;
            end else begin
                replay_num_d = replay_num_d + 2'd1;
            end
        end
        rewind_pending_d = (rewind_pending_q || req) && !rewind_go;

        if (rewind_go) begin
            state_d = ST_REPLAY;
        end else if ((state_q == ST_REPLAY) && (rd_ptr_d == wr_ptr_d)) begin
            state_d = ST_NORMAL;
        end

        // Timer runs only while sent frames wait for an ACK in NORMAL.
        if (purge || rewind_go || expire || (state_q != ST_NORMAL) ||
            (rd_ptr_q == ack_ptr_q)) begin
            timer_d = '0;
        end else if (!rewind_pending_q) begin
            timer_d = timer_q + TW'(1);
        end

        frame_ready_d   = ((wr_ptr_d - ack_ptr_d) < PW'(DEPTH)) &&
                          (state_d == ST_NORMAL) && !rewind_pending_d;
        tx_valid_d      = (rd_ptr_d != wr_ptr_d);
        // Bypass the RAM when the next beat is the frame being written now.
        tx_data_d       = (wr_en && (rd_ptr_d[AW-1:0] == wr_ptr_q[AW-1:0])) ?
                          frame_in : mem_q[rd_ptr_d[AW-1:0]];
        replay_active_d = (state_d == ST_REPLAY);
        dllp_err_d      = bad;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q         <= '0;
            ack_ptr_q        <= '0;
            rd_ptr_q         <= '0;
            state_q          <= ST_NORMAL;
            rewind_pending_q <= 1'b0;
            timer_q          <= '0;
            replay_num_q     <= '0;
            frame_ready_q    <= 1'b0;
            tx_valid_q       <= 1'b0;
            tx_data_q        <= '0;
            replay_active_q  <= 1'b0;
            retrain_q        <= 1'b0;
            dllp_err_q       <= 1'b0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            ack_ptr_q        <= ack_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            state_q          <= state_d;
            rewind_pending_q <= rewind_pending_d;
            timer_q          <= timer_d;
            replay_num_q     <= replay_num_d;
            frame_ready_q    <= frame_ready_d;
            tx_valid_q       <= tx_valid_d;
            tx_data_q        <= tx_data_d;
            replay_active_q  <= replay_active_d;
            retrain_q        <= retrain_d;
            dllp_err_q       <= dllp_err_d;
        end
    end

    // Frame RAM write port.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= frame_in;
        end
    end

`ifdef REPLAY_STATS_EN
    logic [15:0] replay_cnt_q, replay_cnt_d;

    // Saturating count of applied rewinds.
    always_comb begin
        replay_cnt_d = replay_cnt_q;
        if (rewind_go && (replay_cnt_q != 16'hFFFF)) begin
            replay_cnt_d = replay_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            replay_cnt_q <= '0;
        end else begin
            replay_cnt_q <= replay_cnt_d;
        end
    end

    assign replay_cnt = replay_cnt_q;
`else
    assign replay_cnt = 16'd0;
`endif

    assign frame_ready   = frame_ready_q;
    assign tx_valid      = tx_valid_q;
    assign tx_data       = tx_data_q;
    assign replay_active = replay_active_q;
    assign retrain       = retrain_q;
    assign dllp_err      = dllp_err_q;

endmodule

// File: doc/replay_buf.md
Name: replay_buf

Overview:
- Data-link-layer transmit replay buffer; sits directly downstream of the LCRC/sequence-stamping stage.
- Accepts sequence-stamped, CRC-protected TLP frames, stores them until acknowledged, and forwards them to the PHY transmit interface.
- Processes ACK/NAK DLLPs: purges acknowledged frames and replays outstanding frames on NAK or replay-timer expiry.
- Counts consecutive replays and requests link retrain on rollover.

Parameters:
- DEPTH, 8, number of frame slots; must be a power of two, at most 2^(SEQ_W-1).
- DATA_W, 128, frame width.
- SEQ_W, 12, sequence-number width; field sits at frame bits [SEQ_W+111:112].
- TIMEOUT, 1024, replay-timer expiry in clk cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active low.
- frame_in  in  DATA_W  stamped frame from the CRC stage.
- frame_valid  in  1  frame_in valid.
- frame_ready  out  1  buffer accepts frame this cycle.
- dllp_valid  in  1  ACK/NAK DLLP present (single-cycle pulse).
- dllp_nak  in  1  1 = NAK, 0 = ACK.
- dllp_seq  in  SEQ_W  AckNak_Seq_Num.
- tx_data  out  DATA_W  frame to PHY.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  PHY accepts beat.
- replay_active  out  1  high while in REPLAY state.
- retrain  out  1  one-cycle link-retrain request.
- dllp_err  out  1  one-cycle pulse when a DLLP names a sequence number that is not outstanding.
- replay_cnt  out  16  replay statistics counter (see Optional Feature).

Behaviour:
- Reset (rst=0 at a clk edge): all pointers, count, timer and replay_num set to 0; state NORMAL. frame_ready=0, tx_valid=0, replay_active=0, retrain=0, dllp_err=0, replay_cnt=0. RAM contents are not cleared. Reset applied mid-operation discards all outstanding frames.
- Pointers:
  - wr_ptr: next free slot.
  - ack_ptr: oldest unacknowledged slot.
  - rd_ptr: next slot to transmit.
  - All pointers are log2(DEPTH)+1 bits wide. count = wr_ptr - ack_ptr; full when count == DEPTH.
- Write: frame_ready = (count < DEPTH) && state == NORMAL && !rewind_pending. A write stores frame_in at wr_ptr; wr_ptr increments on the next edge.
- Transmit:
  - tx_valid = (rd_ptr != wr_ptr); tx_data = mem[rd_ptr].
  - A frame written at edge N is presented at the earliest at cycle N+1.
  - rd_ptr advances on tx_valid && tx_ready.
  - tx_data must stay stable while tx_valid && !tx_ready.
- ACK/NAK purge:
  - oldest_seq = seq field of mem[ack_ptr]; n = (dllp_seq - oldest_seq + 1) mod 2^SEQ_W.
  - If 1 <= n <= (rd_ptr - ack_ptr): ack_ptr += n, replay_num <= 0, timer <= 0.
  - Else if n == 0 (duplicate of last ACK): no action.
  - Else: dllp_err pulse; no purge, no replay.
- NAK: after the purge rule above (including the n == 0 case), request a replay. Exception: a NAK that raises dllp_err does not request a replay.
- Replay timer:
  - Counts while state == NORMAL and rd_ptr != ack_ptr; holds 0 otherwise.
  - Expiry at TIMEOUT-1 requests a replay.
  - An ACK purge in the same cycle as expiry wins: timer clears, no replay.
- Replay request:
  - Sets rewind_pending.
  - Rewind applies on the first cycle with no stalled beat (tx_valid==0, or a handshake that cycle): rd_ptr <= ack_ptr, state <= REPLAY, timer <= 0.
  - replay_num (2 bits) increments. If replay_num == 3 when a replay is requested, retrain pulses for one cycle and replay_num wraps to 0; the replay still proceeds.
- REPLAY state:
  - replay_active=1 and frame_ready=0.
  - ACKs purge normally. If ack_ptr passes rd_ptr, rd_ptr <= ack_ptr.
  - A NAK in REPLAY restarts the replay from the new ack_ptr; this counts as a replay.
  - Exit to NORMAL when rd_ptr == wr_ptr; the timer restarts from 0.
- Simultaneous frame write and DLLP purge: both apply; count reflects both.

Optional Feature:
- Macro REPLAY_STATS_EN.
- Defined: replay_cnt increments by 1 on every applied rewind, saturating at 16'hFFFF; cleared by reset.
- Undefined: replay_cnt tied to 0 and no counter logic is instantiated.

Test Plan:
- Reset: write 3 frames seq 0,1,2 with tx_ready=1 -> tx_data shows them in order, one per cycle; count=3; ACK seq 1 -> count=1, oldest_seq=2.
- Full: tx_ready=1, no ACKs, write 8 frames seq 0..7 -> frame_ready=0 after 8th write; ACK 3 -> frame_ready=1, count=4.
- NAK: 4 outstanding (seq 10..13), NAK seq 11 -> seq 10,11 purged; replay_active=1; tx_data replays seq 12,13 in order; then NORMAL.
- Timeout: 1 outstanding frame, TIMEOUT=16, no DLLP -> replay starts 16 cycles after first transmit. After 4 consecutive timeouts, retrain pulses once; with REPLAY_STATS_EN, replay_cnt=4.
- Stale DLLP: outstanding seq 5..6, ACK seq 9 -> dllp_err pulse, count unchanged. ACK seq 4 -> no error, no change.
- Collision: timer expiry same cycle as ACK covering 1 frame -> no replay, timer=0. Mid-replay rst=0 -> tx_valid=0, count=0 next cycle.
